datapath_sequencer: RTL

//  Multi-cycle controller that sequences the fetch/decode/execute/writeback stages around the existing datapath.
//  - Fetch: owns the PC and fetches over an instruction-memory req/ack handshake.
//  - Decode: latches the 32-bit instruction register (IR) that feeds the decode stage.
//  - Execute: holds the ALU stage for a configurable latency.
//  - Writeback: pulses the register-file write enable once per retired instruction.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_opcode_classify.sv | 24 ++
 rtl/datapath_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer.
// Consumed by datapath_sequencer and seq_opcode_classify.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_IMM   = 6'h3F;
  localparam logic [5:0] OP_HALT  = 6'h3E;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam int PC_STEP = 4;

  function automatic logic [5:0] opcode_of(
    input logic [31:0] ir
  );
    return ir[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/seq_opcode_classify.sv
// Combinational opcode classifier for the decode step.
// Exactly one of is_exec/is_halt/is_illegal is high.
module seq_opcode_classify
  import seq_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_exec,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_exec    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE),
      (opcode == OP_IMM):  is_exec    = 1'b1;
      (opcode == OP_HALT): is_halt    = 1'b1;
      default:             is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller.
// Optional fetch timeout enabled by defining SEQ_TIMEOUT_EN.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int                   PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC       = '0,
  parameter int                   ALU_LATENCY    = 1,
  parameter int                   TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic                alu_en,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic                timeout,
  output logic [31:0]         retired
);

  localparam int LW =
    (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  state_t state_q;
  state_t state_d;

  logic [LW-1:0] lat_q;
  logic          lat_done;
  logic          tmo_hit;
  logic          is_exec;
  logic          is_halt;
  logic          is_illegal;

  seq_opcode_classify u_classify (
    .opcode     (opcode_of(instr)),
    .is_exec    (is_exec),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign lat_done = (lat_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack)     state_d = DECODE;
        else if (tmo_hit) state_d = HALT;
      end
      DECODE: begin
        // halt and illegal opcodes both park in HALT
        if (is_exec) state_d = EXECUTE;
        else         state_d = HALT;
      end
      EXECUTE: begin
        if (lat_done) state_d = WRITEBACK;
      end
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;
  assign alu_en    = (state_q == EXECUTE);
  assign rf_we     = (state_q == WRITEBACK);
  assign halted    = (state_q == HALT);
  assign busy      = (state_q == FETCH)
                   | (state_q == DECODE)
                   | (state_q == EXECUTE)
                   | (state_q == WRITEBACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
      lat_q   <= '0;
      illegal <= 1'b0;
    end else begin
      if (state_q == FETCH && imem_ack)
        instr <= imem_rdata;
      // counter loads in DECODE so it is fresh on EXECUTE entry
      if (state_q == DECODE) begin
        lat_q <= LW'(ALU_LATENCY - 1);
        if (is_illegal) illegal <= 1'b1;
      end else if (state_q == EXECUTE && !lat_done) begin
        lat_q <= lat_q - 1'b1;
      end
      if (state_q == WRITEBACK) begin
        pc      <= pc + PC_WIDTH'(PC_STEP);
        retired <= retired + 32'd1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_flag;

  assign tmo_hit = (state_q == FETCH) && !imem_ack
                && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // held at zero outside FETCH, so every entry starts clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q    <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state_q != FETCH) tmo_q <= '0;
      else if (!imem_ack)   tmo_q <= tmo_q + 1'b1;
      if (tmo_hit) tmo_flag <= 1'b1;
    end
  end

  assign timeout = tmo_flag;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
